// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle over WIDTH/DIGIT cycles.
// Subtraction support is compiled in only when SERIAL_ADDSUB_SUB_EN is defined.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sub_en_c;
    logic             load_c;
    logic [DIGIT:0]   sum_c;
    logic             msb_cin_c;

`ifdef SERIAL_ADDSUB_SUB_EN
    assign sub_en_c = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign sub_en_c   = 1'b0;
`endif

    // One digit step; carry into the digit MSB recovered from the sum bit and its operands.
    assign sum_c     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    assign msb_cin_c = sum_c[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) load_c = 1'b1;
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = sum_c[DIGIT];
                res_d[WIDTH-1:0] = (res_q[WIDTH-1:0] >> DIGIT)
                                 | (WIDTH'(sum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d       = DONE;
                    done_d        = 1'b1;
                    res_d[WIDTH]  = sum_c[DIGIT] ^ sub_q;
                    ovf_d         = msb_cin_c ^ sum_c[DIGIT];
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                if (start) load_c  = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accepted start: subtraction is A + ~B + 1.
        if (load_c) begin
            state_d = RUN;
            busy_d  = 1'b1;
            a_d     = a;
            b_d     = sub_en_c ? ~b : b;
            carry_d = sub_en_c;
            sub_d   = sub_en_c;
            cnt_d   = CW'(STEPS);
            res_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = res_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4 instances against an arithmetic model.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        sel   = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy8, done8, ovf8, busy16, done16, ovf16;
    logic [8:0]  res8;
    logic [16:0] res16;
    logic        start8, start16;
    logic        obs_busy, obs_done, obs_ovf;
    logic [32:0] obs_res;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign start8   = start && !sel;
    assign start16  = start && sel;
    assign obs_busy = sel ? busy16 : busy8;
    assign obs_done = sel ? done16 : done8;
    assign obs_ovf  = sel ? ovf16  : ovf8;
    assign obs_res  = sel ? 33'(res16) : 33'(res8);

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .sub(sub),
        .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .result(res8), .overflow(ovf8)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .sub(sub),
        .a(a[15:0]), .b(b[15:0]),
        .busy(busy16), .done(done16), .result(res16), .overflow(ovf16)
    );

    // Returns {overflow, result} from plain integer arithmetic.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic sb);
        longint m, ua, ub, sa, sbv, r, sr;
        logic   ov;
        m   = longint'(1) << w;
        ua  = longint'(av) & (m - 1);
        ub  = longint'(bv) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (sb && SUB_EN) begin
            r  = (ua - ub) & (2 * m - 1);
            sr = sa - sbv;
        end else begin
            r  = ua + ub;
            sr = sa + sbv;
        end
        ov = (sr >= m / 2) || (sr < -(m / 2));
        return {ov, 33'(r)};
    endfunction

    // Issues one operation (called #1 after an edge) and measures busy cycles and done latency.
    task automatic do_op(input logic s, input logic [31:0] av, input logic [31:0] bv, input logic sb,
                         output logic [32:0] r, output logic ov, output int nbusy, output int lat);
        sel = s; a = av; b = bv; sub = sb; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
        nbusy = 0; lat = -1; r = '0; ov = 1'b0;
        for (int i = 0; i < 64 && lat < 0; i++) begin
            if (obs_busy) nbusy++;
            if (obs_done) begin
                lat = i; r = obs_res; ov = obs_ovf;
            end else begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        checks++; if (res8 !== 9'h000) begin errors++; $display("FAIL reset_result got %h want 000", res8); end
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", ovf8); end
        checks++; if (res16 !== 17'h0) begin errors++; $display("FAIL reset_result16 got %h want 0", res16); end
        sel = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_over_start got busy %b want 0", busy8); end
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy %b want 0", busy8); end
    endtask

    task automatic test_directed();
        logic [32:0] r; logic ov; int nb, lat; logic [33:0] e;
        do_op(1'b0, 32'd200, 32'd100, 1'b0, r, ov, nb, lat);
        checks++; if (r !== 33'h12C) begin errors++; $display("FAIL add_200_100 got %h want 12c", r); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL add_200_100_ovf got %b want 0", ov); end
        checks++; if (nb !== 8) begin errors++; $display("FAIL busy_cycles8 got %0d want 8", nb); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL done_latency8 got %0d want 8", lat); end
        do_op(1'b0, 32'd5, 32'd7, 1'b1, r, ov, nb, lat);
        e = model(8, 32'd5, 32'd7, 1'b1);
        checks++; if ({ov, r} !== e) begin errors++; $display("FAIL sub_5_7 got %h/%b want %h/%b", r, ov, e[32:0], e[33]); end
        do_op(1'b0, 32'h80, 32'd1, 1'b1, r, ov, nb, lat);
        e = model(8, 32'h80, 32'd1, 1'b1);
        checks++; if ({ov, r} !== e) begin errors++; $display("FAIL sub_80_1 got %h/%b want %h/%b", r, ov, e[32:0], e[33]); end
        do_op(1'b1, 32'hFFFF, 32'h0001, 1'b0, r, ov, nb, lat);
        checks++; if (r !== 33'h10000) begin errors++; $display("FAIL add16_ffff_1 got %h want 10000", r); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL add16_ffff_1_ovf got %b want 0", ov); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL busy_cycles16 got %0d want 4", nb); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL done_latency16 got %0d want 4", lat); end
    endtask

    task automatic test_random();
        logic [32:0] r; logic ov; int nb, lat; logic [33:0] e;
        logic s, sb; logic [31:0] av, bv; int w;
        for (int i = 0; i < 60; i++) begin
            s  = 1'($urandom);
            sb = 1'($urandom);
            av = $urandom; bv = $urandom;
            w  = s ? 16 : 8;
            do_op(s, av, bv, sb, r, ov, nb, lat);
            e = model(w, av, bv, sb);
            checks++;
            if ({ov, r} !== e || nb !== w / (s ? 4 : 1))
                begin errors++; $display("FAIL random_%0d w=%0d a=%h b=%h sub=%b got %h/%b busy=%0d want %h/%b",
                                         i, w, av, bv, sb, r, ov, nb, e[32:0], e[33]); end
            if ($urandom_range(0, 2) == 0) begin @(posedge clock); #1; end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] r; logic ov; int nb, lat;
        do_op(1'b0, 32'd127, 32'd1, 1'b0, r, ov, nb, lat);
        checks++; if (r !== 33'h080) begin errors++; $display("FAIL add_127_1 got %h want 080", r); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL add_127_1_ovf got %b want 1", ov); end
        checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL b2b_in_done got done %b want 1", done8); end
        do_op(1'b0, 32'd1, 32'd1, 1'b0, r, ov, nb, lat);
        checks++; if (r !== 33'h002) begin errors++; $display("FAIL b2b_result got %h want 002", r); end
        checks++; if (nb !== 8 || lat !== 8) begin errors++; $display("FAIL b2b_timing got busy=%0d lat=%0d want 8/8", nb, lat); end
    endtask

    task automatic test_start_in_run();
        int ndone; logic [32:0] r; logic [33:0] e;
        sel = 1'b0; a = 32'd10; b = 32'd20; sub = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start = 1'b1; a = 32'd99; b = 32'd77; sub = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ndone = 0; r = '0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin ndone++; r = 33'(res8); end
            @(posedge clock); #1;
        end
        e = model(8, 32'd10, 32'd20, 1'b0);
        checks++; if (ndone !== 1) begin errors++; $display("FAIL start_in_run_pulses got %0d want 1", ndone); end
        checks++; if (r !== e[32:0]) begin errors++; $display("FAIL start_in_run_result got %h want %h", r, e[32:0]); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        sel = 1'b0; a = 32'd50; b = 32'd60; sub = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy8); end
        checks++; if (res8 !== 9'h000) begin errors++; $display("FAIL abort_result got %h want 000", res8); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8 !== 1'b0) seen++;
            @(posedge clock); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_in_run();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
